// File: rtl/imem_loader.sv
// Boot loader: assembles a count-prefixed byte stream into 16-bit words for the instruction memory.
// Optional trailing XOR checksum is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd5
    } state_t;
`endif

    state_t      state_q;
    logic [7:0]  count_q;
    logic [7:0]  index_q;
    logic [7:0]  hi_q;
    logic        rx_ready_q;
    logic        wr_en_q;
    logic [7:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
    logic        err_q;
`endif

    // rx_ready is a register, so accept never feeds back combinationally into it
    assign accept = rx_valid & rx_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_COUNT;
            count_q    <= '0;
            index_q    <= '0;
            hi_q       <= '0;
            rx_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_COUNT: if (accept) begin
                    count_q <= rx_data;
                    index_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_q   <= rx_data;
`endif
                    state_q <= S_HI;
                end
                S_HI: if (accept) begin
                    hi_q    <= rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_q   <= xor_q ^ rx_data;
`endif
                    state_q <= S_LO;
                end
                S_LO: if (accept) begin
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= BASE_ADDR + index_q;
                    wr_data_q  <= {hi_q, rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_q      <= xor_q ^ rx_data;
`endif
                    rx_ready_q <= 1'b0;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    // count of 0 wraps to 8'hFF here, giving a 256-word image
                    if (index_q == count_q - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        rx_ready_q <= 1'b1;
                        state_q    <= S_CHK;
`else
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_DONE;
`endif
                    end else begin
                        index_q    <= index_q + 8'd1;
                        rx_ready_q <= 1'b1;
                        state_q    <= S_HI;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: if (accept) begin
                    rx_ready_q <= 1'b0;
                    if (rx_data == xor_q) begin
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign rx_ready = rx_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule
